column_neighbor_fetch: RTL and testbench
========================================

COLUMN_NEIGHBOR_FETCH -- requirements
Module: column_neighbor_fetch

Streams one column of the hex-grid snowflake state out of the u/v column RAMs. Each beat is one cell plus its vertical neighbours, handed to the diffusion solver stage.

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 11, meaning cells per column (legal range 2..65535).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning RAM address width.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high; clock clk.
REQ-005 SHALL have port start, input, 1, request to stream one column.
REQ-006 SHALL have port beta, input, 18, signed 2.16 boundary u value.
REQ-007 SHALL have port rd_addr, output, ADDR_W, shared read address to the u and v RAMs.
REQ-008 SHALL have ports rd_data_u and rd_data_v, input, 18 each, RAM read data valid one cycle after rd_addr.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the beat handshake.
REQ-010 SHALL have port out_idx, output, ADDR_W, cell index of the beat.
REQ-011 SHALL have ports out_u_curr, out_u_top, out_u_bot and out_v_curr, output, 18 each, signed 2.16.
REQ-012 SHALL have port out_last, output, 1, high on the beat with out_idx = NUM_CELLS-1.
REQ-013 SHALL have ports busy (output, 1) and done (output, 1, one-cycle pulse).

Function
REQ-014 SHALL implement the FSM IDLE -> PRIME -> STREAM -> DONE -> IDLE.
REQ-015 SHALL leave IDLE only when start=1 is sampled; start SHALL be ignored in all other states.
REQ-016 PRIME SHALL issue reads for cell 0, then cell 1, in consecutive cycles, and load them into a 3-entry window {top, cur, bot}.
REQ-017 Without COL_WRAP_EN, out_valid SHALL first rise exactly 3 cycles after the start-sampling edge.
REQ-018 A beat transfers only on a rising edge where out_valid=1 and out_ready=1.
REQ-019 On each transfer the window SHALL shift by one cell, rd_addr SHALL advance by one, and out_idx SHALL increment.
REQ-020 With out_ready held high, one beat SHALL transfer per cycle.
REQ-021 While out_valid=1 and out_ready=0, rd_addr, the window and all out_* SHALL hold unchanged. No skid buffer is used; the RAM re-presents the held address.
REQ-022 For cell 0, out_u_top SHALL equal beta; for cell NUM_CELLS-1, out_u_bot SHALL equal beta.
REQ-023 All other cells SHALL have out_u_top = u[idx-1] and out_u_bot = u[idx+1].
REQ-024 No reads beyond address NUM_CELLS-1 SHALL be issued; rd_addr SHALL saturate there.
REQ-025 After the out_last transfer, the FSM SHALL enter DONE, deassert out_valid, pulse done for one cycle, then return to IDLE.
REQ-026 busy SHALL be high in PRIME, STREAM and DONE.
REQ-027 A start asserted in the DONE cycle SHALL be ignored; a start asserted in the following IDLE cycle SHALL be accepted.
REQ-028 Data SHALL pass through with no arithmetic and no width change.

Reset
REQ-029 Reset SHALL force IDLE regardless of state, including mid-stream, and discard any partial column.
REQ-030 Reset SHALL drive rd_addr=0, out_valid=0, out_last=0, done=0, busy=0, out_idx=0 and all data outputs to 0.

Configuration
REQ-031 Macro COL_WRAP_EN SHALL select column wrap-around.
REQ-032 With COL_WRAP_EN defined, PRIME SHALL first read cell NUM_CELLS-1, then cells 0 and 1, and first out_valid SHALL rise 4 cycles after start.
REQ-033 With COL_WRAP_EN defined, cell 0 SHALL use out_u_top = u[NUM_CELLS-1], and cell NUM_CELLS-1 SHALL use out_u_bot = u[0] from a held copy.
REQ-034 Without COL_WRAP_EN, REQ-017 and REQ-022 apply and beta substitutes at both edges.

Verification
REQ-035 Fill u[i]=i*0x400, v[i]=0x100+i, beta=0x04000, NUM_CELLS=11, out_ready=1, pulse start -> valid at start+3; 11 consecutive beats; idx5 gives top=0x01000, cur=0x01400, bot=0x01800, v=0x105; idx0 top=0x04000; idx10 bot=0x04000 with out_last=1; done one cycle after.
REQ-036 Same fill, out_ready low for 4 cycles at idx3 -> outputs frozen at idx3 values, rd_addr constant, no beat lost or duplicated.
REQ-037 Toggle out_ready every cycle -> exactly 11 beats, indices 0..10 in order.
REQ-038 Assert reset at idx6 -> next cycle out_valid=0, busy=0; a new start replays from idx0.
REQ-039 Start pulsed while busy -> ignored; exactly one column emitted.
REQ-040 COL_WRAP_EN build, same fill -> valid at start+4; idx0 top=0x02800; idx10 bot=0x00000.

Source files
------------

// File: rtl/column_neighbor_fetch.sv
// Streams one hex-grid column from the u/v RAMs as {top, cur, bot} beats with a valid/ready handshake.
// Define COL_WRAP_EN to wrap the column ends onto each other instead of substituting beta.
module column_neighbor_fetch #(
  parameter int NUM_CELLS = 11,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [17:0]       beta,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [17:0]       rd_data_u,
  input  logic [17:0]       rd_data_v,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [17:0]       out_u_curr,
  output logic [17:0]       out_u_top,
  output logic [17:0]       out_u_bot,
  output logic [17:0]       out_v_curr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_CELLS - 1);
  localparam logic [ADDR_W-1:0] NEXT_TO_LAST = ADDR_W'(NUM_CELLS - 2);
`ifdef COL_WRAP_EN
  localparam logic [1:0]        LAST_PH     = 2'd3;
  localparam logic [ADDR_W-1:0] PRIME_ADDR0 = ADDR_W'(NUM_CELLS - 1);
  localparam logic [ADDR_W-1:0] PH_ADDR_OFS = ADDR_W'(0);
`else
  localparam logic [1:0]        LAST_PH     = 2'd2;
  localparam logic [ADDR_W-1:0] PRIME_ADDR0 = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PH_ADDR_OFS = ADDR_W'(1);
`endif

  state_t            state_reg;
  logic [1:0]        ph_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] prime_addr;
  logic [17:0]       edge_u_reg;
  logic [17:0]       v_bot_reg;
  logic [17:0]       bot_in;
  logic              fire;
  logic              shift_en;

  assign fire = out_valid & out_ready;

  // Address leads the window by one cell during a transfer, so a stall simply
  // re-presents the held address and the RAM output stays aligned.
  assign rd_addr = (fire && addr_reg != LAST_IDX) ? addr_reg + ADDR_W'(1) : addr_reg;

  always_comb begin
    prime_addr = ADDR_W'(ph_reg) + PH_ADDR_OFS;
    if (prime_addr > LAST_IDX) prime_addr = LAST_IDX;
  end

  assign shift_en = (state_reg == PRIME && ph_reg != 2'd0) || (fire && !out_last);
  assign bot_in   = (fire && out_idx == NEXT_TO_LAST) ? edge_u_reg : rd_data_u;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      ph_reg     <= 2'd0;
      addr_reg   <= '0;
      edge_u_reg <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg  <= PRIME;
            ph_reg     <= 2'd0;
            addr_reg   <= PRIME_ADDR0;
            edge_u_reg <= beta;
            out_idx    <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b1;
          end
        end
        PRIME: begin
          ph_reg <= ph_reg + 2'd1;
          if (ph_reg != LAST_PH) addr_reg <= prime_addr;
`ifdef COL_WRAP_EN
          // Cell 0 arrives on this phase; keep it as the bottom neighbour of the last cell.
          if (ph_reg == 2'd2) edge_u_reg <= rd_data_u;
`endif
          if (ph_reg == LAST_PH) begin
            state_reg <= STREAM;
            out_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (fire) begin
            addr_reg <= rd_addr;
            if (out_last) begin
              state_reg <= DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx  <= out_idx + ADDR_W'(1);
              out_last <= (out_idx == NEXT_TO_LAST);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          addr_reg  <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Window preloaded with beta so the non-wrapping prime leaves beta as cell 0's top.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_u_top  <= '0;
      out_u_curr <= '0;
      out_u_bot  <= '0;
      out_v_curr <= '0;
      v_bot_reg  <= '0;
    end else if (state_reg == IDLE && start) begin
      out_u_top  <= beta;
      out_u_curr <= beta;
      out_u_bot  <= beta;
      out_v_curr <= '0;
      v_bot_reg  <= '0;
    end else if (shift_en) begin
      out_u_top  <= out_u_curr;
      out_u_curr <= out_u_bot;
      out_u_bot  <= bot_in;
      out_v_curr <= v_bot_reg;
      v_bot_reg  <= rd_data_v;
    end
  end

endmodule

// File: tb/tb_column_neighbor_fetch.sv
// Directed bench for column_neighbor_fetch: full column, stalls, toggled ready, mid-stream reset, ignored starts.
module tb_column_neighbor_fetch;
  localparam int N  = 11;
  localparam int AW = 16;
  localparam logic [17:0] BETA = 18'h04000;
`ifdef COL_WRAP_EN
  localparam int LAT  = 4;
  localparam bit WRAP = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic [17:0]   beta, rd_data_u, rd_data_v;
  logic [AW-1:0] rd_addr, out_idx;
  logic [17:0]   out_u_curr, out_u_top, out_u_bot, out_v_curr;
  logic          out_valid, out_last, busy, done;
  logic [17:0]   u_mem [16];
  logic [17:0]   v_mem [16];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  column_neighbor_fetch #(.NUM_CELLS(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .beta(beta), .rd_addr(rd_addr),
    .rd_data_u(rd_data_u), .rd_data_v(rd_data_v), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_u_curr(out_u_curr),
    .out_u_top(out_u_top), .out_u_bot(out_u_bot), .out_v_curr(out_v_curr),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    rd_data_u <= u_mem[rd_addr[3:0]];
    rd_data_v <= v_mem[rd_addr[3:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] u_of(input int i);
    return 18'(i * 'h400);
  endfunction

  function automatic logic [17:0] exp_top(input int i);
    if (i == 0) return WRAP ? u_of(N - 1) : BETA;
    return u_of(i - 1);
  endfunction

  function automatic logic [17:0] exp_bot(input int i);
    if (i == N - 1) return WRAP ? u_of(0) : BETA;
    return u_of(i + 1);
  endfunction

  function automatic int sat(input int a);
    return (a > N - 1) ? N - 1 : a;
  endfunction

  task automatic wait_valid();
    int lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) chk("busy_prime", busy, 1);
    end while (!out_valid && lat < 20);
    chk("first_valid_latency", lat, LAT);
  endtask

  task automatic start_col(input bit hold_start);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = hold_start;
    wait_valid();
  endtask

  // mode 0: ready high, 1: 4-cycle stall at idx3, 2: ready toggles, 3: ready high with start held
  task automatic collect(input int mode);
    int idx = 0;
    int cyc = 0;
    int stalls = 0;
    while (idx < N && cyc < 200) begin
      @(negedge clk);
      cyc++;
      case (mode)
        1:       out_ready = !(out_valid && out_idx == 3 && stalls < 4);
        2:       out_ready = cyc[0];
        default: out_ready = 1'b1;
      endcase
      if (mode == 1 && !out_ready) stalls++;
      if (mode == 3 && idx == N - 1) start = 1'b0;
      #1;
      $display("beat mode=%0d cyc=%0d ready=%0b idx=%0d top=%h cur=%h bot=%h v=%h last=%0b addr=%0d",
               mode, cyc, out_ready, out_idx, out_u_top, out_u_curr, out_u_bot, out_v_curr, out_last, rd_addr);
      chk("valid", out_valid, 1);
      chk("idx", out_idx, idx);
      chk("u_top", out_u_top, exp_top(idx));
      chk("u_curr", out_u_curr, u_of(idx));
      chk("u_bot", out_u_bot, exp_bot(idx));
      chk("v_curr", out_v_curr, 18'('h100 + idx));
      chk("last", out_last, idx == N - 1);
      chk("rd_addr", rd_addr, out_ready ? sat(idx + 3) : sat(idx + 2));
      if (mode == 0 && idx == 5) begin
        chk("idx5_top", out_u_top, 18'h01000);
        chk("idx5_cur", out_u_curr, 18'h01400);
        chk("idx5_bot", out_u_bot, 18'h01800);
        chk("idx5_v", out_v_curr, 18'h00105);
      end
      if (mode == 0 && idx == 0) chk("idx0_top", out_u_top, WRAP ? 18'h02800 : 18'h04000);
      if (mode == 0 && idx == N - 1) chk("idx10_bot", out_u_bot, WRAP ? 18'h00000 : 18'h04000);
      if (out_ready) idx++;
    end
    chk("beat_count", idx, N);
    if (mode == 1) chk("stall_cycles", stalls, 4);
  endtask

  // After the last beat: DONE cycle, then IDLE; optionally poke start in both.
  task automatic finish_col(input bit restart);
    @(negedge clk); start = restart; #1;
    chk("done_pulse", done, 1);
    chk("valid_after_last", out_valid, 0);
    chk("busy_in_done", busy, 1);
    @(negedge clk); #1;
    chk("done_cleared", done, 0);
    chk("busy_idle", busy, 0);
    if (restart) begin
      @(posedge clk); #1; start = 1'b0;
      wait_valid();
    end else begin
      start = 1'b0;
    end
  endtask

  initial begin
    int n;
    int seen;
    for (int i = 0; i < 16; i++) begin
      u_mem[i] = (i < N) ? u_of(i) : 18'h3ffff;
      v_mem[i] = (i < N) ? 18'('h100 + i) : 18'h3ffff;
    end
    beta = BETA; reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_u_top", out_u_top, 0);
    chk("rst_v_curr", out_v_curr, 0);
    reset = 1'b0;

    start_col(1'b0); collect(0); finish_col(1'b0);
    start_col(1'b0); collect(1); finish_col(1'b0);
    start_col(1'b0); collect(2); finish_col(1'b0);

    out_ready = 1'b1;
    start_col(1'b0);
    n = 0;
    while (out_idx != 16'd6 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("reached_idx6", out_idx, 6);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_idx", out_idx, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    reset = 1'b0;
    start_col(1'b0); collect(0); finish_col(1'b0);

    start_col(1'b1); collect(3); finish_col(1'b1);
    collect(0); finish_col(1'b0);

    seen = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (out_valid || busy) seen++;
    end
    chk("idle_quiet", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
